// File: rtl/acc_cpu_core.sv
// ---------------------------------------------------------------------------
// acc_cpu_core
//
// Multicycle 16-bit accumulator CPU driving a single-port block RAM that holds
// both program and data. A Moore FSM issues one RAM address per cycle and
// allows for the RAM's one-cycle registered read latency.
//
// Instruction word: opcode = [DATA_W-1 -: 3], operand address X = [ADDR_W-1:0].
//   0 ADD  A = A + M[X]        4 STA  M[X] = A
//   1 NAND A = ~(A & M[X])     5 JZ   if (A == 0) PC = X
//   2 SUB  A = A - M[X]        6 JMP  PC = X
//   3 LDA  A = M[X]            7 HLT
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   o_we        RAM write enable (high only in S_DECODE of a STA)
//   o_addr      RAM address
//   o_data_out  RAM write data, always the accumulator
//   i_data_in   RAM read data, valid the cycle after its address
//   o_pc        current program counter (debug)
//   o_acc       current accumulator (debug)
//   o_halted    high while in S_HALT
//
// RAM interface timing: there is no valid/ready handshake. The RAM accepts an
// address every cycle; a write happens at the rising edge that ends a cycle
// with o_we high, and read data for the address presented in cycle N appears
// on i_data_in during cycle N+1. The core only samples i_data_in in S_LATCH
// (instruction) and S_EXEC (operand), each one cycle after the matching
// address was driven.
// ---------------------------------------------------------------------------
module acc_cpu_core #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data_out,
  input  logic [DATA_W-1:0] i_data_in,
  output logic [ADDR_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_acc,
  output logic              o_halted
);

  // The opcode field is 3 bits, so DATA_W - ADDR_W must equal 3.
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_LDA  = 3'd3;
  localparam logic [2:0] OP_STA  = 3'd4;
  localparam logic [2:0] OP_JZ   = 3'd5;
  localparam logic [2:0] OP_JMP  = 3'd6;
  localparam logic [2:0] OP_HLT  = 3'd7;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_LATCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_ir;

  state_t              w_next_state;
  logic [ADDR_W-1:0]   w_pc_next;
  logic [DATA_W-1:0]   w_acc_next;
  logic [DATA_W-1:0]   w_ir_next;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [2:0]          w_opcode;
  logic [ADDR_W-1:0]   w_operand;

  assign w_opcode  = r_ir[DATA_W-1 -: 3];
  assign w_operand = r_ir[ADDR_W-1:0];

  // State and datapath registers. Reset is immediate, so an in-flight
  // instruction is abandoned and o_we drops in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_acc   <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
      r_acc   <= w_acc_next;
      r_ir    <= w_ir_next;
    end
  end

  // Next-state and Moore outputs. i_data_in only feeds w_ir_next and
  // w_acc_next, which land in registers; no output depends on it directly.
  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    w_acc_next   = r_acc;
    w_ir_next    = r_ir;
    w_we         = 1'b0;
    w_addr       = r_pc;

    case (r_state)
      S_FETCH: begin
        w_next_state = S_LATCH;
      end

      S_LATCH: begin
        // o_addr stays at PC; that read result is never used.
        w_ir_next    = i_data_in;
        w_pc_next    = r_pc + PC_ONE;
        w_next_state = S_DECODE;
      end

      S_DECODE: begin
        case (w_opcode)
          OP_ADD, OP_NAND, OP_SUB, OP_LDA: begin
            w_addr       = w_operand;
            w_next_state = S_EXEC;
          end
          OP_STA: begin
            // The write finishes at this edge, so a store into the next
            // instruction word is seen by the following fetch.
            w_addr       = w_operand;
            w_we         = 1'b1;
            w_next_state = S_FETCH;
          end
          OP_JZ: begin
            if (r_acc == '0) begin
              w_pc_next = w_operand;
            end
            w_next_state = S_FETCH;
          end
          OP_JMP: begin
            w_pc_next    = w_operand;
            w_next_state = S_FETCH;
          end
          OP_HLT: begin
            w_next_state = S_HALT;
          end
          default: begin
            w_next_state = S_FETCH;
          end
        endcase
      end

      S_EXEC: begin
        // Operand read issued in S_DECODE is on i_data_in now.
        case (w_opcode)
          OP_ADD:  w_acc_next = r_acc + i_data_in;
          OP_NAND: w_acc_next = ~(r_acc & i_data_in);
          OP_SUB:  w_acc_next = r_acc - i_data_in;
          OP_LDA:  w_acc_next = i_data_in;
          default: w_acc_next = r_acc;
        endcase
        w_next_state = S_FETCH;
      end

      S_HALT: begin
        w_next_state = S_HALT;
      end

      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

  assign o_we       = w_we;
  assign o_addr     = w_addr;
  assign o_data_out = r_acc;
  assign o_pc       = r_pc;
  assign o_acc      = r_acc;
  assign o_halted   = (r_state == S_HALT);

endmodule

// File: doc/acc_cpu_core.md
Name: acc_cpu_core

Overview:
Multicycle 16-bit accumulator CPU that drives the single-port block RAM holding both program and data. It issues one memory address per cycle through a Moore FSM and accounts for the RAM's one-cycle registered read latency. It writes back through the RAM's write-enable port. It is the stage directly upstream of the RAM and consumes its read data.

Parameters:
ADDR_W, 13, memory address width; PC width.
DATA_W, 16, word width; accumulator, IR and RAM data width. The constraint DATA_W - ADDR_W == 3 is fixed because the opcode field is 3 bits.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
o_we  output  1  RAM write enable.
o_addr  output  ADDR_W  RAM address.
o_data_out  output  DATA_W  RAM write data; always equals the accumulator A.
i_data_in  input  DATA_W  RAM read data; valid the cycle after its address is presented.
o_pc  output  ADDR_W  current PC (debug).
o_acc  output  DATA_W  current A (debug).
o_halted  output  1  high while in S_HALT.

Behaviour:
- Instruction word: opcode = bits[15:13]; operand address X = bits[12:0].
- Opcodes:
  - 0 ADD: A = A + M[X]
  - 1 NAND: A = ~(A & M[X])
  - 2 SUB: A = A - M[X]
  - 3 LDA: A = M[X]
  - 4 STA: M[X] = A
  - 5 JZ: if A == 0 then PC = X
  - 6 JMP: PC = X
  - 7 HLT
- Arithmetic: DATA_W-bit modulo, no flags, no carry. PC increments modulo 2^ADDR_W, so 0x1FFF wraps to 0x0000.
- Reset (async, immediate): state = S_FETCH, PC = RESET_PC, A = 0, IR = 0. Consequently o_we = 0, o_addr = RESET_PC and o_halted = 0 while rst is high.
- Outputs are decoded combinationally from state and registers only; there is no path from i_data_in to any output.
- S_FETCH: o_addr = PC, o_we = 0. Next state S_LATCH.
- S_LATCH: IR <= i_data_in; PC <= PC + 1; o_addr = PC (don't-care read). Next state S_DECODE.
- S_DECODE: action depends on IR opcode.
  - ADD/NAND/SUB/LDA: o_addr = IR[12:0]. Next state S_EXEC.
  - STA: o_addr = IR[12:0], o_we = 1. Next state S_FETCH.
  - JZ: PC <= IR[12:0] only if A == 0, evaluated with A's value in this cycle. Next state S_FETCH.
  - JMP: PC <= IR[12:0]. Next state S_FETCH.
  - HLT: next state S_HALT.
- S_EXEC: A <= f(A, i_data_in) per opcode; o_addr = PC. Next state S_FETCH.
- S_HALT: o_halted = 1, o_we = 0, o_addr = PC. Stays here until reset; PC and A are frozen.
- Instruction latencies, counted from S_FETCH to the next S_FETCH:
  - ALU/LDA: 4 cycles.
  - STA/JZ/JMP: 3 cycles.
- o_we is high only in S_DECODE with opcode STA. Exactly one write per STA.
- Reset asserted mid-instruction: the instruction is aborted. o_we drops in the same cycle, so no partial or late write reaches the RAM, and A is not updated.
- Self-modifying code is legal: a STA to the next instruction's address is visible at the following fetch, because the write completes in S_DECODE before the next S_FETCH read.

Test Plan:
1. Basic program. Preload M[0]=0x6064 (LDA 100), M[1]=0x0065 (ADD 101), M[2]=0x8066 (STA 102), M[3]=0xE000 (HLT), M[100]=5, M[101]=7. Release reset. Required: M[102]=12; o_halted rises exactly 14 cycles after the first S_FETCH; o_acc=12; o_pc=4.
2. SUB/NAND wrap. A=0x0000 via LDA of M[100]=0, then SUB of M[101]=1 gives A=0xFFFF. NAND of M[102]=0x00FF gives A=0xFF00. ADD of M[103]=0x0100 gives A=0x0000 (overflow wraps).
3. JZ both paths.
   - A=0, JZ 0x0040 (0xA040) at address 5: next fetch address is 0x0040.
   - A=3, same instruction: next fetch address is 0x0006.
   - Neither case asserts o_we.
4. PC wrap. Program does JMP 0x1FFF (0xDFFF); M[0x1FFF] holds LDA 100. Required: after executing 0x1FFF, the next o_addr in S_FETCH is 0x0000.
5. Reset mid-STA. Assert rst during the S_DECODE cycle of a STA. Required: o_we=0 in that same cycle, target word unchanged, PC=0, A=0, fetch restarts at address 0 after rst deasserts.
6. Halt hold. After HLT, run 100 cycles. Required: o_halted=1, o_we=0 throughout; o_pc and o_acc constant; reset pulse returns o_halted to 0.
